// File: rtl/cmp_sched_pkg.sv
// rtl/cmp_sched_pkg.sv - shared types, result encoding and id-width helper for cmp_scheduler
package cmp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // {alb, aeb, asb}; exactly one bit set for any comparison
    localparam logic [2:0] RES_ALB = 3'b100;
    localparam logic [2:0] RES_AEB = 3'b010;
    localparam logic [2:0] RES_ASB = 3'b001;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmp_core.sv
// rtl/cmp_core.sv - combinational unsigned three-way magnitude comparator
module cmp_core
    import cmp_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             alb,
    output logic             aeb,
    output logic             asb
);

    logic [2:0] res;

    always_comb begin
        res = RES_ASB;
        if (a > b) begin
            res = RES_ALB;
        end else if (a == b) begin
            res = RES_AEB;
        end
    end

    assign {alb, aeb, asb} = res;

endmodule

// File: rtl/cmp_scheduler.sv
// rtl/cmp_scheduler.sv - round-robin scheduler sharing one comparator; CMP_SCHED_STATS_EN adds rsp_count
module cmp_scheduler
    import cmp_sched_pkg::*;
#(
    parameter int  N_REQ = 4,
    parameter int  WIDTH = 4,
    localparam int ID_W  = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_alb,
    output logic                   rsp_aeb,
    output logic                   rsp_asb
`ifdef CMP_SCHED_STATS_EN
    ,
    output logic [15:0]            rsp_count
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gidx;
    logic [ID_W-1:0]   id_q;
    logic              found;
    logic              accept;
    logic              hs;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              c_alb;
    logic              c_aeb;
    logic              c_asb;
    int                j;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && req_valid[j]) begin
                found = 1'b1;
                gidx  = ID_W'(j);
            end
        end
    end

    // Gated by rst_n so no grant is visible while reset is held
    assign accept = rst_n && (state == IDLE) && found;
    assign hs     = (state == RESP) && rsp_ready;

    always_comb begin
        req_ready       = '0;
        req_ready[gidx] = accept;
    end

    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_nxt = CMP;
                end
            end
            CMP: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_cmp_core (
        .a   (a_q),
        .b   (b_q),
        .alb (c_alb),
        .aeb (c_aeb),
        .asb (c_asb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rsp_id  <= '0;
            rsp_alb <= 1'b0;
            rsp_aeb <= 1'b0;
            rsp_asb <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= req_a[gidx*WIDTH +: WIDTH];
                b_q  <= req_b[gidx*WIDTH +: WIDTH];
                id_q <= gidx;
            end
            // Result registers only load in CMP, so they hold after the handshake
            if (state == CMP) begin
                rsp_id  <= id_q;
                rsp_alb <= c_alb;
                rsp_aeb <= c_aeb;
                rsp_asb <= c_asb;
            end
            if (hs) begin
                rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
            end
        end
    end

`ifdef CMP_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_count <= '0;
        end else if (hs && (rsp_count != 16'hFFFF)) begin
            rsp_count <= rsp_count + 16'd1;
        end
    end
`endif

endmodule
